// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the test run sequencer: default widths, FSM encodings, seed payload.
package test_sequencer_pkg;

    localparam int unsigned WIDTH_DEF         = 32;
    localparam int unsigned COUNT_W_DEF       = 16;
    localparam int unsigned ERR_W_DEF         = 16;
    localparam int unsigned DRAIN_TIMEOUT_DEF = 64;

    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } seed_pair_t;

endpackage

// File: rtl/test_sequencer_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Run controller: seeds the operand LFSRs, issues N vectors, collects N monitor checks, reports.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned COUNT_W       = COUNT_W_DEF,
    parameter int unsigned ERR_W         = ERR_W_DEF,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [COUNT_W-1:0] i_num_vectors,
    input  logic [WIDTH-1:0]   i_seed_a,
    input  logic [WIDTH-1:0]   i_seed_b,
    input  logic               i_mon_valid,
    input  logic               i_mon_mismatch,
    output logic               o_lfsr_load,
    output logic [WIDTH-1:0]   o_lfsr_seed_a,
    output logic [WIDTH-1:0]   o_lfsr_seed_b,
    output logic               o_lfsr_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_timeout,
    output logic [COUNT_W-1:0] o_vec_count,
    output logic [COUNT_W-1:0] o_chk_count,
    output logic [ERR_W-1:0]   o_err_count,
    output logic [COUNT_W-1:0] o_first_err_idx
);

    localparam int unsigned WAIT_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [COUNT_W-1:0] num;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               first_seen;
    seed_pair_t         seeds;

    logic start_ok;
    logic abort_ok;
    logic chk_take;
    logic err_take;
    logic drain_expire;

    assign o_lfsr_seed_a = seeds.a;
    assign o_lfsr_seed_b = seeds.b;

    // Event qualification and next-state; abort overrides every other transition.
    always_comb begin
        start_ok     = 1'b0;
        abort_ok     = 1'b0;
        chk_take     = 1'b0;
        err_take     = 1'b0;
        drain_expire = 1'b0;
        state_nxt    = state;

        abort_ok = i_abort && ((state == ST_SEED) || (state == ST_RUN) || (state == ST_DRAIN));
        start_ok = i_start && !i_abort && ((state == ST_IDLE) || (state == ST_DONE));
        chk_take = i_mon_valid && ((state == ST_RUN) || (state == ST_DRAIN)) && (o_chk_count < num);
        err_take = chk_take && i_mon_mismatch;
        drain_expire = (state == ST_DRAIN) && (o_chk_count != num) && !i_mon_valid &&
                       (wait_cnt == WAIT_W'(DRAIN_TIMEOUT - 1));

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = (i_num_vectors == '0) ? ST_DONE : ST_SEED;
                end
            end
            ST_SEED:  state_nxt = ST_RUN;
            ST_RUN: begin
                if ((o_vec_count + COUNT_W'(1)) == num) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((o_chk_count == num) || drain_expire) begin
                    state_nxt = ST_DONE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase

        if (abort_ok) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output and counter registers; LFSR controls follow the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_lfsr_load     <= 1'b0;
            o_lfsr_en       <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_timeout       <= 1'b0;
            o_vec_count     <= '0;
            o_chk_count     <= '0;
            o_first_err_idx <= '0;
            first_seen      <= 1'b0;
            num             <= '0;
            seeds           <= '0;
            wait_cnt        <= '0;
        end else begin
            o_lfsr_load <= (state_nxt == ST_SEED);
            o_lfsr_en   <= (state_nxt == ST_RUN);
            o_busy      <= (state_nxt == ST_SEED) || (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);

            if (start_ok) begin
                num             <= i_num_vectors;
                seeds.a         <= i_seed_a;
                seeds.b         <= i_seed_b;
                o_vec_count     <= '0;
                o_chk_count     <= '0;
                o_first_err_idx <= '0;
                first_seen      <= 1'b0;
                o_timeout       <= 1'b0;
                wait_cnt        <= '0;
                o_done          <= (i_num_vectors == '0);
                o_pass          <= (i_num_vectors == '0);
            end else begin
                if (state == ST_RUN) begin
                    o_vec_count <= o_vec_count + COUNT_W'(1);
                end
                if (chk_take) begin
                    o_chk_count <= o_chk_count + COUNT_W'(1);
                end
                if (err_take && !first_seen) begin
                    o_first_err_idx <= o_chk_count;
                    first_seen      <= 1'b1;
                end
                if (state == ST_DRAIN) begin
                    wait_cnt <= i_mon_valid ? '0 : wait_cnt + WAIT_W'(1);
                end else begin
                    wait_cnt <= '0;
                end
                if (drain_expire && !abort_ok) begin
                    o_timeout <= 1'b1;
                end
                // A DRAIN exit never coincides with a counted mismatch, so the live count is final.
                if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                    o_done <= 1'b1;
                    o_pass <= (o_err_count == '0) && !drain_expire;
                end
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .inc   (err_take),
        .count (o_err_count)
    );

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: directed scenarios plus random runs against a run-level model.
module tb_test_sequencer;

    localparam int unsigned DT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_num_vectors;
    logic [31:0] i_seed_a;
    logic [31:0] i_seed_b;
    logic        i_mon_valid;
    logic        i_mon_mismatch;

    logic        load, en, busy, done, pass, timeout;
    logic [31:0] seed_a, seed_b;
    logic [15:0] vec, chk, err, first;

    logic        s_load, s_en, s_busy, s_done, s_pass, s_timeout;
    logic [31:0] s_seed_a, s_seed_b;
    logic [15:0] s_vec, s_chk, s_first;
    logic [1:0]  s_err;

    always #5 clk = ~clk;

    test_sequencer u_dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_num_vectors(i_num_vectors), .i_seed_a(i_seed_a), .i_seed_b(i_seed_b),
        .i_mon_valid(i_mon_valid), .i_mon_mismatch(i_mon_mismatch),
        .o_lfsr_load(load), .o_lfsr_seed_a(seed_a), .o_lfsr_seed_b(seed_b),
        .o_lfsr_en(en), .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
        .o_vec_count(vec), .o_chk_count(chk), .o_err_count(err), .o_first_err_idx(first)
    );

    test_sequencer #(.ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_num_vectors(i_num_vectors), .i_seed_a(i_seed_a), .i_seed_b(i_seed_b),
        .i_mon_valid(i_mon_valid), .i_mon_mismatch(i_mon_mismatch),
        .o_lfsr_load(s_load), .o_lfsr_seed_a(s_seed_a), .o_lfsr_seed_b(s_seed_b),
        .o_lfsr_en(s_en), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_timeout(s_timeout),
        .o_vec_count(s_vec), .o_chk_count(s_chk), .o_err_count(s_err), .o_first_err_idx(s_first)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor model and observation state.
    bit [1:0]  hist;
    bit [63:0] mism_map;
    bit        stray;
    bit        en_prev;
    int        delivered, allowed;
    int        cyc = 0;
    int        n_load, n_en, n_rise;
    int        load_at, en_first, last_drive, done_at, to_at;
    logic [31:0] seed_a_seen, seed_b_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the monitor for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (load) begin
            n_load++;
            load_at     = cyc;
            seed_a_seen = seed_a;
            seed_b_seen = seed_b;
        end
        if (en) begin
            if (!en_prev) n_rise++;
            if (n_en == 0) en_first = cyc;
            n_en++;
        end
        en_prev = en;
        if (done && done_at < 0) done_at = cyc;
        if (timeout && to_at < 0) to_at = cyc;
        if (stray) begin
            i_mon_valid    = 1'b1;
            i_mon_mismatch = 1'b1;
        end else if (hist[1] && delivered < allowed) begin
            i_mon_valid    = 1'b1;
            i_mon_mismatch = mism_map[delivered];
            delivered++;
            last_drive = cyc;
        end else begin
            i_mon_valid    = 1'b0;
            i_mon_mismatch = 1'($urandom % 2);
        end
        hist = {hist[0], en};
    endtask

    task automatic clear_obs();
        n_load = 0; n_en = 0; n_rise = 0; load_at = -1; en_first = -1;
        last_drive = -1; done_at = -1; to_at = -1; delivered = 0;
        hist = '0; en_prev = 1'b0; stray = 1'b0;
    endtask

    // One complete run; expectations derived from run-level rules, not cycle mechanics.
    task automatic do_run(input int num, input logic [31:0] sa, input logic [31:0] sb,
                          input int allow, input bit [63:0] map);
        int errs, fidx, exp_chk, start_cyc;
        bit found, exp_to, exp_pass;
        clear_obs();
        mism_map = map;
        allowed  = allow;
        i_start = 1'b1; i_num_vectors = 16'(num); i_seed_a = sa; i_seed_b = sb;
        start_cyc = cyc;
        tick();
        i_start = 1'b0; i_num_vectors = 16'($urandom); i_seed_a = $urandom; i_seed_b = $urandom;
        for (int k = 0; k < 400 && !done; k++) begin
            i_start = (k == 3) && busy;
            tick();
        end
        i_start = 1'b0;

        exp_chk = (delivered < num) ? delivered : num;
        errs = 0; fidx = 0; found = 1'b0;
        for (int j = 0; j < exp_chk; j++) begin
            if (map[j]) begin
                if (!found) fidx = j;
                found = 1'b1;
                errs++;
            end
        end
        exp_to   = (delivered < num);
        exp_pass = (errs == 0) && !exp_to;

        check("done", done, 1);
        check("busy_end", busy, 0);
        check("vec_count", vec, num);
        check("chk_count", chk, exp_chk);
        check("err_count", err, (errs > 65535) ? 65535 : errs);
        check("err_sat", s_err, (errs > 3) ? 3 : errs);
        check("first_err", first, fidx);
        check("timeout", timeout, exp_to);
        check("pass", pass, exp_pass);
        check("pass_sat", s_pass, exp_pass);
        check("load_cycles", n_load, (num > 0) ? 1 : 0);
        check("en_cycles", n_en, num);
        check("en_bursts", n_rise, (num > 0) ? 1 : 0);
        if (num == 0) begin
            check("zero_done_lat", done_at, start_cyc + 1);
        end else begin
            check("en_after_load", en_first, load_at + 1);
            check("seed_a", seed_a_seen, sa);
            check("seed_b", seed_b_seen, sb);
            if (exp_to) begin
                check("timeout_lat", to_at - last_drive, DT + 1);
                check("timeout_done", done_at, to_at);
            end else begin
                check("done_lat", done_at, last_drive + 2);
            end
        end

        // Stray monitor traffic in DONE must not disturb the result.
        stray = 1'b1;
        repeat (3) tick();
        stray = 1'b0;
        tick();
        check("hold_done", done, 1);
        check("hold_pass", pass, exp_pass);
        check("hold_chk", chk, exp_chk);
        check("hold_err", err, (errs > 65535) ? 65535 : errs);
    endtask

    initial begin
        reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_num_vectors = '0;
        i_seed_a = '0; i_seed_b = '0; i_mon_valid = 1'b0; i_mon_mismatch = 1'b0;
        clear_obs();
        allowed = 0; mism_map = '0;
        tick(); tick();
        check("rst_ctrl", {load, en, busy, done, pass, timeout}, 0);
        check("rst_seeds", seed_a | seed_b, 0);
        check("rst_counts", {vec, chk}, 0);
        check("rst_err_first", {err, first}, 0);
        reset = 1'b1;
        tick();

        do_run(4, 32'h1, 32'h2, 4, 64'h0);
        do_run(8, $urandom, $urandom, 8, (64'h1 << 3) | (64'h1 << 6));
        do_run(0, $urandom, $urandom, 0, 64'h0);
        do_run(5, $urandom, $urandom, 3, 64'h0);
        do_run(6, $urandom, $urandom, 6, 64'h3E);

        // Abort during the third enable cycle of a ten-vector run.
        clear_obs();
        allowed = 64; mism_map = '0;
        i_start = 1'b1; i_num_vectors = 16'd10; tick(); i_start = 1'b0;
        for (int k = 0; k < 20 && n_en < 3; k++) tick();
        check("abort_reach", n_en, 3);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check("abort_en", en, 0);
        check("abort_state", {load, busy, done}, 0);
        check("abort_vec", vec, 3);
        i_start = 1'b1; i_abort = 1'b1; i_num_vectors = 16'd4; tick();
        i_start = 1'b0; i_abort = 1'b0;
        check("startabort_idle", {load, busy, done}, 0);
        tick();
        check("startabort_hold", {load, en, busy}, 0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 24));
            do_run(n, $urandom, $urandom, n, {$urandom, $urandom} & {$urandom, $urandom});
        end

        // Reset asserted mid-run clears every output register.
        clear_obs();
        allowed = 64; mism_map = '1;
        i_start = 1'b1; i_num_vectors = 16'd10; i_seed_a = 32'hA5A5_0001; i_seed_b = 32'h5A5A_0002;
        tick(); i_start = 1'b0;
        for (int k = 0; k < 20 && n_en < 2; k++) tick();
        check("midrst_reach", n_en, 2);
        reset = 1'b0; tick();
        check("midrst_ctrl", {load, en, busy, done, pass, timeout}, 0);
        check("midrst_seeds", seed_a | seed_b, 0);
        check("midrst_counts", {vec, chk}, 0);
        check("midrst_err_first", {err, first}, 0);
        check("midrst_sat", {s_err, s_busy, s_en, s_load}, 0);
        reset = 1'b1; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
